// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder for the RV32I data port.
// One request at a time over valid/ready. Word-organised synchronous RAM
// with read-modify-write for sub-word stores, sign/zero-extended loads and
// a memory-mapped output port register.
module dmem_responder #(
  parameter int                ADDR_W       = 16,
  parameter int                DEPTH_WORDS  = 1024,
  parameter logic [ADDR_W-1:0] OUTPORT_ADDR = 16'hfffc
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       outport
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Request fields captured at accept; the req_* inputs are don't-care afterwards.
  logic             lat_we;
  logic [2:0]       lat_funct3;
  logic [1:0]       lat_off;
  logic [IDX_W-1:0] lat_idx;
  logic [15:0]      lat_wdata;

  // RAM port.
  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      ram_q;
  logic             ram_re;
  logic             ram_we;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram_wdata;

  // Request decode, evaluated on the live inputs while in IDLE.
  logic             req_is_out;
  logic             req_err;
  logic             req_is_word_st;
  logic [IDX_W-1:0] req_idx;

  // Select the addressed lane of a word and extend it per funct3.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_BYTE:   load_extend = {{24{b[7]}}, b};
      F3_BYTE_U: load_extend = {24'h0, b};
      F3_HALF:   load_extend = {{16{h[15]}}, h};
      F3_HALF_U: load_extend = {16'h0, h};
      default:   load_extend = word;
    endcase
  endfunction

  // Replace one byte or half lane of a word, leaving the other lanes intact.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic        is_half,
                                              input logic [1:0]  off,
                                              input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (!is_half)    m[{off, 3'b000} +: 8] = wd[7:0];
    else if (off[1]) m[31:16] = wd;
    else             m[15:0]  = wd;
    return m;
  endfunction

  // Outport is decoded on its word address so byte lanes of that word map to it.
  always_comb begin
    req_idx        = req_addr[IDX_W+1:2];
    req_is_out     = (req_addr[ADDR_W-1:2] == OUTPORT_ADDR[ADDR_W-1:2]);
    req_is_word_st = req_we && (req_funct3 == F3_WORD);
    req_err        = 1'b0;
    case (req_funct3)
      F3_BYTE:            req_err = req_is_out && req_we;
      F3_HALF:            req_err = req_addr[0] || (req_is_out && req_we);
      F3_WORD:            req_err = (req_addr[1:0] != 2'b00);
      F3_BYTE_U:          req_err = req_we;
      F3_HALF_U:          req_err = req_we || req_addr[0];
      default:            req_err = 1'b1;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: single-edge class goes straight to RESP, the rest read first.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) begin
        if (req_err || req_is_out || req_is_word_st) state_nxt = RESP;
        else                                         state_nxt = READ;
      end
      READ:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output and RAM-control decode from the current state.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_idx   = req_idx;
    ram_wdata = req_wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_err && !req_is_out) begin
          ram_we = req_is_word_st;
          ram_re = !req_is_word_st;
        end
      end
      READ: begin
        ram_idx   = lat_idx;
        ram_wdata = store_merge(ram_q, lat_funct3[0], lat_off, lat_wdata);
        ram_we    = lat_we;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Synchronous single-port RAM; write and read never coincide.
  // NOTE: the array has no reset; clearing it would turn the RAM into flops.
  // A reset during READ still blocks the write because ram_we follows state.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_idx];
  end

  // Request latch, response data/error and outport register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_off    <= 2'b00;
      lat_idx    <= '0;
      lat_wdata  <= 16'h0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
      outport    <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lat_we     <= req_we;
          lat_funct3 <= req_funct3;
          lat_off    <= req_addr[1:0];
          lat_idx    <= req_idx;
          lat_wdata  <= req_wdata[15:0];
          rsp_err    <= req_err;
          rsp_rdata  <= 32'h0;
          if (!req_err && req_is_out) begin
            if (req_we) outport   <= req_wdata;
            else        rsp_rdata <= load_extend(outport, req_funct3, req_addr[1:0]);
          end
        end
        READ: if (!lat_we) rsp_rdata <= load_extend(ram_q, lat_funct3, lat_off);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder with a byte-level reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] outport;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state.
  logic [31:0] m_mem [1024];
  logic [31:0] m_out;

  dmem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .outport    (outport)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Behavioural model of one access: legality, latency class, data and side effects.
  function automatic void model_access(input bit we, input bit [2:0] f3, input bit [15:0] a,
                                       input bit [31:0] wd, output bit err,
                                       output bit [31:0] rd, output int lat);
    int idx  = (int'(a) / 4) % 1024;
    int off  = int'(a) % 4;
    bit out  = (a / 4) == (16'hfffc / 4);
    int size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bit [31:0] src;
    bit [31:0] mask;
    bit [31:0] v;
    err = (f3 == 3) || (f3 >= 6) || (we && f3 >= 4) || (off % size != 0) ||
          (out && we && size != 4);
    rd  = 0;
    lat = 1;
    if (err) return;
    if (out) begin
      src = m_out;
      if (we) m_out = wd;
    end else begin
      src = m_mem[idx];
      lat = (we && size == 4) ? 1 : 2;
      if (we) begin
        v = src;
        for (int k = 0; k < size; k++) begin
          v = v & ~(32'hff << (8 * (off + k)));
          v = v | (((wd >> (8 * k)) & 32'hff) << (8 * (off + k)));
        end
        m_mem[idx] = v;
      end
    end
    if (!we) begin
      mask = (size == 4) ? 32'hffffffff : ((32'h1 << (8 * size)) - 1);
      v = (src >> (8 * off)) & mask;
      if (f3 < 4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
      rd = v;
    end
  endfunction

  // Issue one request, check latency, response and outport, then complete the handshake.
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [15:0] a,
                        input bit [31:0] wd, input bit rr_early, input string tag);
    bit        e;
    bit [31:0] r;
    int        lat;
    int        n;
    model_access(we, f3, a, wd, e, r, lat);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rsp_ready  = rr_early;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = 16'($urandom);
    req_wdata  = $urandom;
    n = 1;
    while (!rsp_valid && n < 8) begin
      @(posedge clk); #1; n++;
    end
    check({tag, " lat"}, 32'(n), 32'(lat));
    check({tag, " err"}, 32'(rsp_err), 32'(e));
    check({tag, " rdata"}, rsp_rdata, r);
    check({tag, " outport"}, outport, m_out);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, " done"}, {31'h0, rsp_valid, req_ready} , 32'h1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit [31:0] held;
    bit        we;
    bit [2:0]  f3;
    bit [15:0] a;
    bit        e;
    bit [31:0] r;
    int        lat;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 16'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    m_out = 32'h0;
    for (int i = 0; i < 1024; i++) m_mem[i] = 32'h0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst outport", outport, 32'h0);

    // Preload the working region so every later RAM load has defined data.
    for (int w = 0; w < 16; w++) do_req(1'b1, 3'b010, 16'(w * 4), $urandom, 1'b0, "preload");

    // Lane selection and extension.
    do_req(1'b1, 3'b010, 16'h0010, 32'hdeadbeef, 1'b0, "st_word");
    do_req(1'b0, 3'b000, 16'h0013, 32'h0, 1'b0, "ld_byte");
    do_req(1'b0, 3'b100, 16'h0012, 32'h0, 1'b0, "ld_byte_u");
    do_req(1'b0, 3'b001, 16'h0010, 32'h0, 1'b0, "ld_half");
    do_req(1'b0, 3'b101, 16'h0012, 32'h0, 1'b0, "ld_half_u");
    // Read-modify-write stores.
    do_req(1'b1, 3'b000, 16'h0011, 32'h12345677, 1'b0, "st_byte");
    do_req(1'b0, 3'b010, 16'h0010, 32'h0, 1'b0, "ld_after_sb");
    do_req(1'b1, 3'b001, 16'h0012, 32'h0000abcd, 1'b1, "st_half");
    do_req(1'b0, 3'b010, 16'h0010, 32'h0, 1'b1, "ld_after_sh");
    // Output port.
    do_req(1'b1, 3'b010, 16'hfffc, 32'h000000a5, 1'b0, "st_outport");
    do_req(1'b0, 3'b010, 16'hfffc, 32'h0, 1'b0, "ld_outport");
    // Illegal requests, then confirm nothing changed.
    do_req(1'b0, 3'b001, 16'h0011, 32'h0, 1'b0, "err_half_mis");
    do_req(1'b1, 3'b010, 16'h0012, 32'h11111111, 1'b0, "err_word_mis");
    do_req(1'b0, 3'b011, 16'h0010, 32'h0, 1'b0, "err_f3_011");
    do_req(1'b1, 3'b100, 16'h0010, 32'h22222222, 1'b0, "err_st_byte_u");
    do_req(1'b1, 3'b000, 16'hfffc, 32'h33333333, 1'b0, "err_st_outport");
    do_req(1'b0, 3'b010, 16'h0010, 32'h0, 1'b0, "ld_after_err");
    do_req(1'b0, 3'b010, 16'hfffc, 32'h0, 1'b0, "ld_out_after_err");

    // Response stall with rsp_ready low.
    model_access(1'b0, 3'b000, 16'h0013, 32'h0, e, r, lat);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 16'h0013;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    check("stall rsp_valid", 32'(rsp_valid), 32'd1);
    held = rsp_rdata;
    check("stall rdata", held, r);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("stall hold", {29'h0, rsp_valid, req_ready, rsp_err}, 32'h4);
      check("stall data", rsp_rdata, r);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("stall release", 32'(req_ready), 32'd1);

    // Reset while a BYTE store sits in READ.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 16'h0021; req_wdata = 32'h000000c3;
    @(posedge clk); #1; req_valid = 1'b0;
    check("rmw in read", {30'h0, req_ready, rsp_valid}, 32'h0);
    rst_n = 1'b0; #2;
    m_out = 32'h0;
    check("abort req_ready", 32'(req_ready), 32'd1);
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort rdata", rsp_rdata, 32'h0);
    check("abort outport", outport, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 3'b010, 16'h0020, 32'h0, 1'b0, "reread_aborted");

    // Randomised traffic, including illegal encodings and the outport word.
    for (int t = 0; t < 400; t++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      if ($urandom_range(7) == 0) a = 16'hfffc + 16'($urandom_range(3));
      else                        a = 16'($urandom_range(63));
      do_req(we, f3, a, $urandom, 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
